// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   issue request, honoured only in IDLE or DONE
//   op      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b    rs1 / rs2 operands, captured when start is accepted
//   busy    high while iterating (CALC) and during sign fix-up (SIGN)
//   done    one-cycle pulse, result valid in that cycle
//   result  final value, held until the next accepted operation completes

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t              state;
    logic [4:0]          count;
    logic [2:0]          op_r;
    logic [XLEN-1:0]     b_mag_r;
    logic                neg_r;
    // Shared shift register: multiply keeps {partial sum, multiplier},
    // divide keeps {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   acc;

    // Operand preparation for the accept cycle.
    logic                a_signed;
    logic                b_signed;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                neg_in;
    logic                div_zero;
    logic                div_ovf;
    logic                fast;
    logic [XLEN-1:0]     fast_val;

    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        neg_a    = a_signed && a[XLEN-1];
        neg_b    = b_signed && b[XLEN-1];
        a_mag    = neg_a ? (~a + 1'b1) : a;
        b_mag    = neg_b ? (~b + 1'b1) : b;
        // The remainder takes the dividend's sign; everything else the XOR.
        neg_in   = (op == 3'd6) ? neg_a : (neg_a ^ neg_b);
        div_zero = op[2] && (b == '0);
        div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (a == INT_MIN) && (b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_val = op[1] ? a : '1;
        end else begin
            fast_val = op[1] ? '0 : INT_MIN;
        end
    end

    // One multiply step: conditionally add the multiplicand into the high
    // half, then shift the whole register right, keeping the carry.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;

    // One restoring divide step: shift left, trial-subtract the divisor.
    // The shifted remainder needs XLEN+1 bits for the compare, but the
    // difference always fits in XLEN bits when the subtract is kept.
    logic [XLEN:0]       div_part;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_r} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        div_part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = div_part >= {1'b0, b_mag_r};
        div_diff = div_part[XLEN-1:0] - b_mag_r;
        div_next = {(div_ge ? div_diff : div_part[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end

    // Sign fix-up. The product is negated as a whole before slicing so the
    // low half of MUL is independent of operand signs.
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     sign_val;

    always_comb begin
        prod_fix = neg_r ? (~acc + 1'b1) : acc;
        quo_fix  = neg_r ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:          sign_val = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          sign_val = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    sign_val = quo_fix;
            default:       sign_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            op_r    <= '0;
            b_mag_r <= '0;
            neg_r   <= 1'b0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        b_mag_r <= b_mag;
                        neg_r   <= neg_in;
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        count   <= '0;
                        if (fast) begin
                            result <= fast_val;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc   <= op_r[2] ? div_next : mul_next;
                    count <= count + 5'd1;
                    if (count == LAST_ITER) begin
                        state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    result <= sign_val;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
